alu_multicycle: RTL



---
 rtl/alu_multicycle.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Execute-stage ALU behind a valid/ready handshake. Logic, add/sub,
//   compare and branch codes finish in one cycle; shifts run on an
//   iterative shifter moving SHIFT_STEP bits per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   Operation/SrcA/SrcB are valid
//   in_ready   unit can accept a new operation (IDLE only)
//   Operation  4-bit operation code from the ALU controller
//   SrcA       operand A (rs1)
//   SrcB       operand B (rs2/immediate); shifts use SrcB[4:0]
//   out_valid  ALUResult is valid (DONE only)
//   out_ready  consumer accepts the result
//   ALUResult  result; compare/branch codes return the condition in bit 0
module alu_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic [1:0]            state_reg, state_next;
  logic [3:0]            op_reg, op_next;
  logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
  logic [4:0]            rem_reg, rem_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;

  logic [DATA_WIDTH-1:0] fast_result;
  logic [DATA_WIDTH-1:0] shifted;
  logic [4:0]            step;
  logic                  lt_signed;
  logic                  is_shift;

  assign lt_signed = $signed(SrcA) < $signed(SrcB);
  assign is_shift  = (Operation == 4'b0100) || (Operation == 4'b0101) ||
                     (Operation == 4'b0111);

  // Single-cycle result. Shift codes only land here when shamt == 0,
  // in which case the operand passes through unchanged.
  always_comb begin
    fast_result = '0;
    case (Operation)
      4'b0000: fast_result = SrcA & SrcB;
      4'b0001: fast_result = SrcA | SrcB;
      4'b0010: fast_result = SrcA + SrcB;
      4'b0011: fast_result = SrcA ^ SrcB;
      4'b0100: fast_result = SrcA;
      4'b0101: fast_result = SrcA;
      4'b0110: fast_result = SrcA - SrcB;
      4'b0111: fast_result = SrcA;
      4'b1000: fast_result = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      4'b1001: fast_result = {{(DATA_WIDTH-1){1'b0}}, SrcA != SrcB};
      4'b1010: fast_result = {{(DATA_WIDTH-1){1'b0}}, ~lt_signed};
      4'b1011: fast_result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      4'b1100: fast_result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      4'b1101: fast_result = SrcA + SrcB;
      4'b1110: fast_result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      default: fast_result = '0;  // 1111 is illegal and returns zero
    endcase
  end

  // Last partial step clamps to whatever amount is left.
  assign step = (rem_reg < STEP) ? rem_reg : STEP;

  always_comb begin
    case (op_reg)
      4'b0100: shifted = shreg_reg << step;
      4'b0101: shifted = shreg_reg >> step;
      default: shifted = DATA_WIDTH'($signed(shreg_reg) >>> step);
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    shreg_next  = shreg_reg;
    rem_next    = rem_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next = Operation;
          if (is_shift && (SrcB[4:0] != 5'd0)) begin
            shreg_next = SrcA;
            rem_next   = SrcB[4:0];
            state_next = SHIFT;
          end else begin
            result_next = fast_result;
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        // Shift while bits remain; the cycle that finds nothing left
        // latches the shifter into the result register.
        if (rem_reg == 5'd0) begin
          result_next = shreg_reg;
          state_next  = DONE;
        end else begin
          shreg_next = shifted;
          rem_next   = rem_reg - step;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      shreg_reg  <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      shreg_reg  <= shreg_next;
      rem_reg    <= rem_next;
      result_reg <= result_next;
    end
  end

  // Ready is masked by reset so nothing looks acceptable while the unit
  // is being held in reset, even though the state already reads IDLE.
  assign in_ready  = (state_reg == IDLE) && !reset;
  assign out_valid = (state_reg == DONE);
  assign ALUResult = result_reg;

endmodule
